serial_deserializer: RTL and testbench

- Serial-in/parallel-out receiver: collects WIDTH bits from a strobed serial line into a word.
- Presents each completed word on a valid/ready output port.
- Sits at the receiving end of a shift-register transmit path (parallel load, shift left/right), supporting both MSB-first and LSB-first bit order.
- Reports lost words through a sticky overrun flag.

---
 rtl/serial_deserializer_pkg.sv | 14 +
 rtl/serial_deserializer_if.sv | 28 ++
 rtl/serial_deserializer_sipo_shift_core.sv | 72 +++++++
 rtl/serial_deserializer.sv | 122 ++++++++++++
 tb/tb_serial_deserializer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_deserializer_pkg.sv
// Shared types and constants for the serial deserializer.
//   state_t   : receive FSM states (IDLE between words, COLLECT mid-word)
//   ORDER_*   : encoding of the captured bit order (matches lsb_first)
package serial_deserializer_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial link plus word output handshake of the deserializer.
//   lsb_first, sin, sin_valid, frame_start : serial side, driven by the sender
//   dout, dout_valid                      : completed word, driven by the deserializer
//   dout_ready                            : consumer acceptance
// master = sender/consumer side, slave = deserializer side.
interface serial_deserializer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             lsb_first;
  logic             sin;
  logic             sin_valid;
  logic             frame_start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output lsb_first, sin, sin_valid, frame_start, dout_ready,
    input  dout, dout_valid
  );

  modport slave (
    input  lsb_first, sin, sin_valid, frame_start, dout_ready,
    output dout, dout_valid
  );

endinterface

// File: rtl/serial_deserializer_sipo_shift_core.sv
// Shift register plus bit counter of the deserializer (sipo_shift_core).
//   clk, reset : clock, async active-high reset
//   clear      : synchronous clear of shift register and counter
//   restart    : drop the partial word before this cycle's bit (frame_start)
//   shift_en   : shift sin in this cycle
//   order      : bit order used for this cycle's shift (ORDER_MSB / ORDER_LSB)
//   sin        : serial bit
//   word_done  : this cycle's bit completes a word (combinational)
//   word       : shift register contents including this cycle's bit (combinational)
module serial_deserializer_sipo_shift_core
  import serial_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             restart,
  input  logic             shift_en,
  input  logic             order,
  input  logic             sin,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, sr_base;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  // Next shift/count value; restart makes this cycle's bit bit 0 of a fresh word.
  always_comb begin
    sr_base   = restart ? '0 : sr_q;
    cnt_base  = restart ? '0 : cnt_q;
    sr_d      = sr_base;
    cnt_d     = cnt_base;
    word_done = 1'b0;
    if (shift_en) begin
      case (order)
        ORDER_MSB: sr_d = {sr_base[WIDTH-2:0], sin};
        ORDER_LSB: sr_d = {sin, sr_base[WIDTH-1:1]};
        default:   sr_d = sr_base;
      endcase
      if (cnt_base == CNT_W'(WIDTH - 1)) begin
        word_done = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_base + CNT_W'(1);
      end
    end
    if (clear) begin
      sr_d      = '0;
      cnt_d     = '0;
      word_done = 1'b0;
    end
  end

  // The holding register loads on the same edge as the final bit, so expose
  // the post-shift value rather than the register.
  assign word = sr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in/parallel-out receiver with valid/ready word output.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous clear of all datapath state and overrun
//   bus        : serial input and word output handshake (slave side)
//   overrun    : sticky, a completed word was dropped while dout was held
//   busy       : a partial word is in progress
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  serial_deserializer_if.slave  bus,
  output logic                  overrun,
  output logic                  busy
);

  state_t           state_q, state_d;
  logic             order_q, order_d;
  logic             first_bit;
  logic             shift_order;
  logic             word_done;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             accept, load, drop;

  serial_deserializer_sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .restart  (bus.frame_start),
    .shift_en (bus.sin_valid),
    .order    (shift_order),
    .sin      (bus.sin),
    .word_done(word_done),
    .word     (word)
  );

  // FSM state and captured bit order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      order_q <= ORDER_MSB;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
    end
  end

  // Next state; bit order is sampled only on bit 0 of a word.
  always_comb begin
    state_d     = state_q;
    order_d     = order_q;
    first_bit   = 1'b0;
    shift_order = order_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      first_bit = bus.sin_valid && ((state_q == IDLE) || bus.frame_start);
      if (first_bit) begin
        order_d     = bus.lsb_first;
        shift_order = bus.lsb_first;
      end
      if (bus.sin_valid) begin
        state_d = word_done ? IDLE : COLLECT;
      end else if (bus.frame_start) begin
        state_d = IDLE;
      end
    end
  end

  // Holding register, handshake and overrun; a word completing while the
  // previous one is still held and not being accepted is dropped.
  always_comb begin
    accept       = dout_valid_q && bus.dout_ready;
    load         = word_done && (!dout_valid_q || bus.dout_ready);
    drop         = word_done && dout_valid_q && !bus.dout_ready;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    if (clear) begin
      dout_d       = '0;
      dout_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      if (load) begin
        dout_d       = word;
        dout_valid_d = 1'b1;
      end else if (accept) begin
        dout_valid_d = 1'b0;
      end
      if (drop) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q == COLLECT);

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer (WIDTH=8): directed scenarios
// plus randomized traffic, all compared every cycle against a word-level model.
module tb_serial_deserializer;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;
  logic clear;
  logic overrun;
  logic busy;

  serial_deserializer_if #(.WIDTH(WIDTH)) bus ();

  serial_deserializer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .bus    (bus),
    .overrun(overrun),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bits received so far, order taken at the first bit.
  bit         m_bits[$];
  logic       m_order;
  logic [7:0] m_hold;
  logic       m_valid;
  logic       m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_order = 1'b0;
    m_hold  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step(input logic cl, input logic fs, input logic sv,
                            input logic s, input logic lsb, input logic rdy);
    logic [7:0] w;
    logic       complete;
    w        = 8'h00;
    complete = 1'b0;
    if (cl) begin
      m_bits.delete();
      m_hold  = 8'h00;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      return;
    end
    if (fs) m_bits.delete();
    if (sv) begin
      if (m_bits.size() == 0) m_order = lsb;
      m_bits.push_back(s);
      if (m_bits.size() == WIDTH) begin
        for (int i = 0; i < 8; i++) begin
          if (m_order) w[i] = m_bits[i];
          else         w[7-i] = m_bits[i];
        end
        m_bits.delete();
        complete = 1'b1;
      end
    end
    if (complete) begin
      if (m_valid && !rdy) m_ovr = 1'b1;
      else begin
        m_hold  = w;
        m_valid = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".dout"},       32'(bus.dout),       32'(m_hold));
    check({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_valid));
    check({tag, ".overrun"},    32'(overrun),        32'(m_ovr));
    check({tag, ".busy"},       32'(busy),           32'(m_bits.size() != 0));
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 unit later.
  task automatic tick(input logic cl, input logic fs, input logic sv,
                      input logic s, input logic lsb, input logic rdy);
    @(negedge clk);
    clear           = cl;
    bus.frame_start = fs;
    bus.sin_valid   = sv;
    bus.sin         = s;
    bus.lsb_first   = lsb;
    bus.dout_ready  = rdy;
    @(posedge clk);
    model_step(cl, fs, sv, s, lsb, rdy);
    #1;
    compare_all("cyc");
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset           = 1'b1;
    clear           = 1'b0;
    bus.frame_start = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.sin         = 1'b0;
    bus.lsb_first   = 1'b0;
    bus.dout_ready  = 1'b0;
    #1;
    model_reset();
    check("rst.dout",       32'(bus.dout),       32'h0);
    check("rst.dout_valid", 32'(bus.dout_valid), 32'h0);
    check("rst.overrun",    32'(overrun),        32'h0);
    check("rst.busy",       32'(busy),           32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Send one word in the given order; later bits carry a random lsb_first
  // that must be ignored, and gap idle cycles follow every bit but the last.
  task automatic send_word(input logic [7:0] w, input logic lsb, input logic rdy_body,
                           input logic rdy_last, input int gap, input logic fs_first);
    for (int i = 0; i < 8; i++) begin
      logic b;
      logic l;
      b = lsb ? w[i] : w[7-i];
      l = (i == 0) ? lsb : 1'($urandom_range(0, 1));
      tick(1'b0, fs_first && (i == 0), 1'b1, b, l, (i == 7) ? rdy_last : rdy_body);
      if (i < 7) begin
        for (int g = 0; g < gap; g++)
          tick(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy_body);
      end
    end
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    reset           = 1'b1;
    clear           = 1'b0;
    bus.frame_start = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.sin         = 1'b0;
    bus.lsb_first   = 1'b0;
    bus.dout_ready  = 1'b0;
    model_reset();
    #1;
    check("init.dout",       32'(bus.dout),       32'h0);
    check("init.dout_valid", 32'(bus.dout_valid), 32'h0);
    check("init.overrun",    32'(overrun),        32'h0);
    check("init.busy",       32'(busy),           32'h0);
    @(negedge clk);
    reset = 1'b0;

    // MSB first 1,1,0,0,0,0,0,1 -> 0xC1, valid for exactly one cycle.
    send_word(8'hC1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    check("msb.dout",  32'(bus.dout),       32'hC1);
    check("msb.valid", 32'(bus.dout_valid), 32'h1);
    idle(1'b1);
    check("msb.valid_drop", 32'(bus.dout_valid), 32'h0);

    // Same bit sequence LSB first -> 0x83, then 0xA5 MSB first back-to-back.
    send_word(8'h83, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    check("lsb.dout", 32'(bus.dout), 32'h83);
    send_word(8'hA5, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    check("b2b.dout",  32'(bus.dout),       32'hA5);
    check("b2b.valid", 32'(bus.dout_valid), 32'h1);
    idle(1'b1);

    // Overrun: 0x12 held, 0x34 dropped.
    send_word(8'h12, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_word(8'h34, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("ovr.dout", 32'(bus.dout), 32'h12);
    check("ovr.flag", 32'(overrun),  32'h1);
    idle(1'b1);
    check("ovr.valid_drop", 32'(bus.dout_valid), 32'h0);
    check("ovr.sticky",     32'(overrun),        32'h1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr.overrun", 32'(overrun), 32'h0);

    // Acceptance on the same edge as the next completion.
    send_word(8'h55, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send_word(8'hAA, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    check("same.dout",    32'(bus.dout),       32'hAA);
    check("same.valid",   32'(bus.dout_valid), 32'h1);
    check("same.overrun", 32'(overrun),        32'h0);
    idle(1'b1);

    // frame_start after 5 bits, then 0x3C.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("fs.busy", 32'(busy), 32'h0);
    send_word(8'h3C, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    check("fs.dout", 32'(bus.dout), 32'h3C);
    idle(1'b1);

    // Same, frame_start riding on bit 0, with 3-cycle gaps.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    send_word(8'h3C, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    check("fsgap.dout",  32'(bus.dout),       32'h3C);
    check("fsgap.valid", 32'(bus.dout_valid), 32'h1);
    idle(1'b1);

    // Reset after 4 bits, then 0xF0.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    apply_reset();
    idle(1'b1);
    send_word(8'hF0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    check("rstw.dout",  32'(bus.dout),       32'hF0);
    check("rstw.valid", 32'(bus.dout_valid), 32'h1);
    idle(1'b1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        apply_reset();
      end else begin
        tick(1'($urandom_range(0, 79) == 0),
             1'($urandom_range(0, 29) == 0),
             1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 9) < 6));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
